regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised NPC integer register file: NR_READ async read ports, one write port, async active-low reset.
//   Adds a per-register pending-write scoreboard so the decode stage can detect RAW/WAW hazards
//   on in-flight instructions. Sits between decode (issue, reads) and writeback (write, busy clear).
// PARAMETERS
//   ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//   DATA_WIDTH  32  register data width
//   NR_READ     2   number of read ports (>=1)
// PORTS
//   Wrclk     in   1                    clock, all state on posedge
//   Rst_n     in   1                    async active-low reset
//   Raddr     in   NR_READ*ADDR_WIDTH   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   Rdata     out  NR_READ*DATA_WIDTH   read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Rbusy     out  NR_READ              1 = port i's register has a write pending
//   RegWr     in   1                    writeback valid
//   Rw        in   ADDR_WIDTH           writeback register index
//   busW      in   DATA_WIDTH           writeback data
//   IssueVld  in   1                    decode issuing an instr writing IssueRd
//   IssueRd   in   ADDR_WIDTH           destination of issuing instr
//   IssueRdy  out  1                    issue accepted this cycle (no WAW)
//   Flush     in   1                    clear all pending-write marks
//   BusyCnt   out  ADDR_WIDTH+1         number of busy registers
// BEHAVIOUR
//   - Reset (Rst_n=0, async): all regs 0, all busy bits 0, BusyCnt=0. Rdata=0 and Rbusy=0 while in reset.
//   - Reg 0 hardwired: reads 0, never busy; writes and issues to 0 change no state.
//   - Write: posedge with RegWr=1 and Rw!=0 -> rf[Rw]<=busW, busy[Rw]<=0. Writing a non-busy reg is legal.
//   - Read: combinational; Rdata_i=rf[Raddr_i], Rbusy_i=busy[Raddr_i] (bypass rules under CONFIGURATION).
//   - IssueRdy = !busy[IssueRd] | (RegWr & Rw==IssueRd) | (IssueRd==0) | Flush. Combinational, no dependence on IssueVld.
//   - Issue accept: IssueVld & IssueRdy at posedge -> busy[IssueRd]<=1 (IssueRd!=0). IssueVld=1 with IssueRdy=0: no state change; decode holds.
//   - Same cycle clear+set of same reg (writeback Rw==IssueRd, issue accepted): data written, busy ends 1.
//   - Flush: posedge -> all busy bits 0; data untouched; a same-cycle write still lands;
//     a same-cycle accepted issue still sets its bit (issue wins over flush).
//   - BusyCnt: registered popcount of busy bits, equals state after each edge; range 0..2**ADDR_WIDTH-1.
//   - Rst_n assertion mid-operation discards pending writes/issues that cycle; no partial update.
//   - Latency: write visible to reads next cycle (0 cycles with bypass); busy set visible next cycle.
// CONFIGURATION
//   RF_BYPASS_EN defined: write-first forwarding. If RegWr & Rw!=0 & Raddr_i==Rw, then Rdata_i=busW
//     and Rbusy_i=0 in the same cycle. IssueRdy unchanged.
//   RF_BYPASS_EN undefined: read-before-write. Rdata_i/Rbusy_i show pre-edge state;
//     decode must stall one extra cycle on Rbusy.
// TESTING
//   1 Reset: drive Rst_n=0 mid-run after writes -> all Rdata=0, Rbusy=0, BusyCnt=0, IssueRdy=1 immediately (async).
//   2 Write/read: RegWr, Rw=5, busW=32'hDEADBEEF; next cycle Raddr port0=5 -> Rdata=DEADBEEF.
//     Rw=0, busW=1 -> reg0 reads 0.
//   3 Scoreboard: issue rd=7 -> Rbusy=1 for reg7, BusyCnt=1. Issue rd=7 again -> IssueRdy=0, BusyCnt stays 1.
//     Write Rw=7 -> busy cleared, BusyCnt=0.
//   4 Simultaneous: busy[9]=1, same cycle RegWr Rw=9 busW=42 plus issue rd=9 -> IssueRdy=1.
//     Next cycle reg9=42, busy[9]=1, BusyCnt unchanged.
//   5 Flush: busy regs 3,4,6 (BusyCnt=3); Flush plus issue rd=10 -> next cycle only reg10 busy, BusyCnt=1.
//   6 Bypass (both builds): RegWr Rw=12 busW=77, Raddr port1=12 same cycle.
//     With RF_BYPASS_EN: Rdata1=77, Rbusy1=0. Without: old value, updated next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of regfile_scoreboard: read ports, writeback, issue and flush.
// master = decode/writeback pipeline side, slave = register file.
interface regfile_scoreboard_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NR_READ    = 2
);
   logic [NR_READ*ADDR_WIDTH-1:0] Raddr;
   logic [NR_READ*DATA_WIDTH-1:0] Rdata;
   logic [NR_READ-1:0]            Rbusy;
   logic                          RegWr;
   logic [ADDR_WIDTH-1:0]         Rw;
   logic [DATA_WIDTH-1:0]         busW;
   logic                          IssueVld;
   logic [ADDR_WIDTH-1:0]         IssueRd;
   logic                          IssueRdy;
   logic                          Flush;
   logic [ADDR_WIDTH:0]           BusyCnt;

   modport master (
      output Raddr, RegWr, Rw, busW, IssueVld, IssueRd, Flush,
      input  Rdata, Rbusy, IssueRdy, BusyCnt
   );

   modport slave (
      input  Raddr, RegWr, Rw, busW, IssueVld, IssueRd, Flush,
      output Rdata, Rbusy, IssueRdy, BusyCnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with NR_READ async read ports, one write port and a pending-write scoreboard.
// Define RF_BYPASS_EN for write-first forwarding on the read ports; default is read-before-write.
module regfile_scoreboard #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NR_READ    = 2
) (
   input  logic                Wrclk,
   input  logic                Rst_n,
   regfile_scoreboard_if.slave bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] rf_reg [DEPTH];
   logic [DEPTH-1:0]      busy_reg;
   logic [DEPTH-1:0]      busy_next;
   logic [CW-1:0]         busy_cnt_reg;
   logic [CW-1:0]         busy_cnt_next;
   logic                  wr_en;
   logic                  issue_acc;

   assign wr_en = bus.RegWr && (bus.Rw != '0);

   // A writeback to the same register frees it this cycle, so the issue may proceed.
   assign bus.IssueRdy = !busy_reg[bus.IssueRd]
                       || (bus.RegWr && (bus.Rw == bus.IssueRd))
                       || (bus.IssueRd == '0)
                       || bus.Flush;
   assign issue_acc    = bus.IssueVld && bus.IssueRdy && (bus.IssueRd != '0);

   // Ordering gives flush < writeback clear < issue set.
   always_comb begin
      busy_next = busy_reg;
      if (bus.Flush) begin
         busy_next = '0;
      end
      if (wr_en) begin
         busy_next[bus.Rw] = 1'b0;
      end
      if (issue_acc) begin
         busy_next[bus.IssueRd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_comb begin
      busy_cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_cnt_next = busy_cnt_next + CW'(busy_next[i]);
      end
   end

   always_ff @(posedge Wrclk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_reg[i] <= '0;
         end
         busy_reg     <= '0;
         busy_cnt_reg <= '0;
      end else begin
         if (wr_en) begin
            rf_reg[bus.Rw] <= bus.busW;
         end
         busy_reg     <= busy_next;
         busy_cnt_reg <= busy_cnt_next;
      end
   end

   assign bus.BusyCnt = busy_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NR_READ; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] ra;
         assign ra = bus.Raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef RF_BYPASS_EN
         // Forwarding is gated by Rst_n so reads stay zero while reset is held.
         logic byp;
         assign byp = Rst_n && wr_en && (ra == bus.Rw);
         assign bus.Rdata[gi*DATA_WIDTH +: DATA_WIDTH] = byp ? bus.busW : rf_reg[ra];
         assign bus.Rbusy[gi] = !byp && busy_reg[ra];
`else
         assign bus.Rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rf_reg[ra];
         assign bus.Rbusy[gi] = busy_reg[ra];
`endif
      end
   endgenerate
endmodule
